// File: rtl/image_ctl_pkg.sv
// image_ctl_pkg: register map, CTRL bit positions, AXI response codes and write-FSM states
package image_ctl_pkg;
    localparam int REG_CTRL      = 0;
    localparam int REG_STATUS    = 1;
    localparam int REG_IRQ_STAT  = 2;
    localparam int REG_IRQ_EN    = 3;
    localparam int REG_CFG_BASE  = 4;
    localparam int IMMEDIATE_BIT = 1;
    typedef enum logic [1:0] {OKAY = 2'b00, SLVERR = 2'b10} axi_resp_e;
    typedef enum logic [1:0] {WR_IDLE, WR_COMMIT, WR_RESP} wr_state_e;
endpackage

// File: rtl/image_ctl_axil_wr.sv
// image_ctl_axil_wr: AXI4-Lite AW/W capture in either order, single-cycle commit strobe and B channel
module image_ctl_axil_wr
    import image_ctl_pkg::*;
#(
    parameter int C_DATA_WIDTH = 32,
    parameter int C_NUM_REGS   = 8,
    parameter int C_ADDR_WIDTH = 8
) (
    input  logic                              ACLK,
    input  logic                              ARESETN,
    input  logic [C_ADDR_WIDTH-1:0]           S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_DATA_WIDTH-1:0]           S_AXI_WDATA,
    input  logic [C_DATA_WIDTH/8-1:0]         S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    output logic                              we,
    output logic [$clog2(C_NUM_REGS)-1:0]     widx,
    output logic [C_DATA_WIDTH-1:0]           wdata,
    output logic [C_DATA_WIDTH/8-1:0]         wstrb
);
    localparam int ADDR_LSB = $clog2(C_DATA_WIDTH/8);
    localparam int IDX_W    = $clog2(C_NUM_REGS);
    wr_state_e state, state_nxt;
    logic aw_held, w_held, aw_hs, w_hs, unused_aw;
    assign unused_aw     = ^{S_AXI_AWADDR, S_AXI_AWPROT};
    assign S_AXI_BVALID  = state == WR_RESP;
    assign S_AXI_BRESP   = OKAY;
    assign S_AXI_AWREADY = ARESETN && !aw_held && !S_AXI_BVALID;
    assign S_AXI_WREADY  = ARESETN && !w_held && !S_AXI_BVALID;
    assign aw_hs         = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_hs          = S_AXI_WVALID && S_AXI_WREADY;
    assign we            = state == WR_COMMIT;
    always_ff @(posedge ACLK) begin
        if (!ARESETN) state <= WR_IDLE;
        else          state <= state_nxt;
    end
    always_comb begin
        state_nxt = state;
        state_nxt = (state == WR_IDLE && (aw_held || aw_hs) && (w_held || w_hs)) ? WR_COMMIT :
                    (state == WR_COMMIT)                                       ? WR_RESP   :
                    (state == WR_RESP && S_AXI_BREADY)                         ? WR_IDLE   : state;
    end
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            widx    <= '0;
            wdata   <= '0;
            wstrb   <= '0;
        end else begin
            if (aw_hs) begin
                aw_held <= 1'b1;
                widx    <= S_AXI_AWADDR[ADDR_LSB +: IDX_W];
            end
            if (w_hs) begin
                w_held <= 1'b1;
                wdata  <= S_AXI_WDATA;
                wstrb  <= S_AXI_WSTRB;
            end
            if (state == WR_COMMIT) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/image_ctl_regs.sv
// image_ctl_regs: AXI4-Lite register file with RO status, W1C interrupts and frame-synchronous config shadows
module image_ctl_regs
    import image_ctl_pkg::*;
#(
    parameter int C_DATA_WIDTH = 32,
    parameter int C_NUM_REGS   = 8,
    parameter int C_ADDR_WIDTH = 8
) (
    input  logic                                         ACLK,
    input  logic                                         ARESETN,
    input  logic [C_ADDR_WIDTH-1:0]                      S_AXI_AWADDR,
    input  logic [2:0]                                   S_AXI_AWPROT,
    input  logic                                         S_AXI_AWVALID,
    output logic                                         S_AXI_AWREADY,
    input  logic [C_DATA_WIDTH-1:0]                      S_AXI_WDATA,
    input  logic [C_DATA_WIDTH/8-1:0]                    S_AXI_WSTRB,
    input  logic                                         S_AXI_WVALID,
    output logic                                         S_AXI_WREADY,
    output logic [1:0]                                   S_AXI_BRESP,
    output logic                                         S_AXI_BVALID,
    input  logic                                         S_AXI_BREADY,
    input  logic [C_ADDR_WIDTH-1:0]                      S_AXI_ARADDR,
    input  logic [2:0]                                   S_AXI_ARPROT,
    input  logic                                         S_AXI_ARVALID,
    output logic                                         S_AXI_ARREADY,
    output logic [C_DATA_WIDTH-1:0]                      S_AXI_RDATA,
    output logic [1:0]                                   S_AXI_RRESP,
    output logic                                         S_AXI_RVALID,
    input  logic                                         S_AXI_RREADY,
    input  logic                                         frame_sync_i,
    input  logic [C_DATA_WIDTH-1:0]                      status_i,
    input  logic [C_DATA_WIDTH-1:0]                      event_i,
    output logic [(C_NUM_REGS-REG_CFG_BASE)*C_DATA_WIDTH-1:0] cfg_o,
    output logic [C_DATA_WIDTH-1:0]                      ctrl_o,
    output logic                                         irq_o
);
    localparam int ADDR_LSB = $clog2(C_DATA_WIDTH/8);
    localparam int IDX_W    = $clog2(C_NUM_REGS);
    localparam int NB       = C_DATA_WIDTH/8;
    logic                    we, unused_rd;
    logic [IDX_W-1:0]        widx, ridx;
    logic [C_DATA_WIDTH-1:0] wdata, wmask, clr;
    logic [NB-1:0]           wstrb;
    logic [C_DATA_WIDTH-1:0] regs [C_NUM_REGS];
    image_ctl_axil_wr #(
        .C_DATA_WIDTH(C_DATA_WIDTH),
        .C_NUM_REGS  (C_NUM_REGS),
        .C_ADDR_WIDTH(C_ADDR_WIDTH)
    ) u_wr (
        .ACLK         (ACLK),
        .ARESETN      (ARESETN),
        .S_AXI_AWADDR (S_AXI_AWADDR),
        .S_AXI_AWPROT (S_AXI_AWPROT),
        .S_AXI_AWVALID(S_AXI_AWVALID),
        .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA  (S_AXI_WDATA),
        .S_AXI_WSTRB  (S_AXI_WSTRB),
        .S_AXI_WVALID (S_AXI_WVALID),
        .S_AXI_WREADY (S_AXI_WREADY),
        .S_AXI_BRESP  (S_AXI_BRESP),
        .S_AXI_BVALID (S_AXI_BVALID),
        .S_AXI_BREADY (S_AXI_BREADY),
        .we           (we),
        .widx         (widx),
        .wdata        (wdata),
        .wstrb        (wstrb)
    );
    assign unused_rd     = ^{S_AXI_ARADDR, S_AXI_ARPROT};
    assign ridx          = S_AXI_ARADDR[ADDR_LSB +: IDX_W];
    assign S_AXI_ARREADY = ARESETN && !S_AXI_RVALID;
    assign S_AXI_RRESP   = OKAY;
    assign clr           = (we && widx == IDX_W'(REG_IRQ_STAT)) ? (wdata & wmask) : '0;
    always_comb begin
        wmask = '0;
        for (int b = 0; b < NB; b++) wmask[b*8 +: 8] = {8{wstrb[b]}};
    end
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            for (int i = 0; i < C_NUM_REGS; i++) regs[i] <= '0;
            ctrl_o       <= '0;
            cfg_o        <= '0;
            irq_o        <= 1'b0;
            S_AXI_RVALID <= 1'b0;
            S_AXI_RDATA  <= '0;
        end else begin
            for (int i = 0; i < C_NUM_REGS; i++)
                if (we && widx == IDX_W'(i) && i != REG_STATUS && i != REG_IRQ_STAT)
                    regs[i] <= (regs[i] & ~wmask) | (wdata & wmask);
            regs[REG_IRQ_STAT] <= (regs[REG_IRQ_STAT] & ~clr) | event_i;
            if (frame_sync_i || regs[REG_CTRL][IMMEDIATE_BIT]) begin
                ctrl_o <= regs[REG_CTRL];
                for (int k = REG_CFG_BASE; k < C_NUM_REGS; k++)
                    cfg_o[(k-REG_CFG_BASE)*C_DATA_WIDTH +: C_DATA_WIDTH] <= regs[k];
            end
            irq_o <= |(regs[REG_IRQ_STAT] & regs[REG_IRQ_EN]);
            if (S_AXI_ARVALID && S_AXI_ARREADY) begin
                S_AXI_RVALID <= 1'b1;
                S_AXI_RDATA  <= (ridx == IDX_W'(REG_STATUS)) ? status_i : regs[ridx];
            end else if (S_AXI_RREADY) begin
                S_AXI_RVALID <= 1'b0;
            end
        end
    end
endmodule
